// File: rtl/timer_pkg.sv
// Shared timer definitions: state encoding and the width/tick-rate constants
// common to the millisecond timebase and its timeout consumers.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

    localparam int TIME_W        = 32;
    localparam int DUR_W         = 16;
    localparam int TICKS_PER_SEC = 1000;

endpackage

// File: rtl/timeout_timer.sv
// Duration timer sampling the free-running time_ms count; expiry is a one-cycle pulse.
// All outputs registered: busy/remaining follow the start edge, expired rises one clock after the deadline tick.
module timeout_timer #(
    parameter int WIDTH = timer_pkg::TIME_W,
    parameter int DUR_W = timer_pkg::DUR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] time_ms,
    input  logic             start,
    input  logic [DUR_W-1:0] dur,
    input  logic             cancel,
    input  logic             pause,
    input  logic             resume,
    output logic             busy,
    output logic             paused,
    output logic             expired,
    output logic [DUR_W-1:0] remaining
);

    timer_pkg::timer_state_t state, state_nxt;
    logic [WIDTH-1:0] stamp, stamp_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [DUR_W-1:0] tgt, tgt_nxt;
    logic [WIDTH-1:0] elapsed;
    logic [WIDTH-1:0] run_elapsed;
    logic             fire;
    logic             busy_nxt, paused_nxt, expired_nxt;
    logic [DUR_W-1:0] remaining_nxt;

    // Modulo subtraction keeps the compare correct across time_ms roll-over.
    assign elapsed = time_ms - stamp;
    assign fire    = (elapsed >= WIDTH'(tgt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= timer_pkg::IDLE;
            stamp     <= '0;
            tgt       <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            paused    <= 1'b0;
            expired   <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            stamp     <= stamp_nxt;
            tgt       <= tgt_nxt;
            acc       <= acc_nxt;
            busy      <= busy_nxt;
            paused    <= paused_nxt;
            expired   <= expired_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        stamp_nxt   = stamp;
        tgt_nxt     = tgt;
        acc_nxt     = acc;
        expired_nxt = 1'b0;
        if (cancel) begin
            state_nxt = timer_pkg::IDLE;
        end else if (start) begin
            stamp_nxt = time_ms;
            tgt_nxt   = dur;
            if (dur == '0) begin
                state_nxt   = timer_pkg::IDLE;
                expired_nxt = 1'b1;
            end else begin
                state_nxt = timer_pkg::RUN;
            end
        end else begin
            case (state)
                timer_pkg::RUN: begin
                    if (fire) begin
                        state_nxt   = timer_pkg::IDLE;
                        expired_nxt = 1'b1;
                    end else if (pause) begin
                        state_nxt = timer_pkg::HOLD;
                        acc_nxt   = elapsed;
                    end
                end
                timer_pkg::HOLD: begin
                    if (resume) begin
                        state_nxt = timer_pkg::RUN;
                        stamp_nxt = time_ms - acc;
                    end
                end
                default: state_nxt = timer_pkg::IDLE;
            endcase
        end
    end

    // Outputs are derived from the next state so they are valid right after the edge.
    always_comb begin
        run_elapsed   = time_ms - stamp_nxt;
        busy_nxt      = (state_nxt != timer_pkg::IDLE);
        paused_nxt    = (state_nxt == timer_pkg::HOLD);
        remaining_nxt = '0;
        case (state_nxt)
            timer_pkg::RUN: begin
                if (run_elapsed < WIDTH'(tgt_nxt))
                    remaining_nxt = tgt_nxt - run_elapsed[DUR_W-1:0];
            end
            timer_pkg::HOLD: remaining_nxt = tgt_nxt - acc_nxt[DUR_W-1:0];
            default:         remaining_nxt = '0;
        endcase
    end

endmodule

// File: doc/timeout_timer.md
# timeout_timer

Consumer-side companion to the free-running millisecond timebase: accepts a duration request, measures elapsed time by sampling the timebase's `time_ms` count, and signals expiry with a one-cycle pulse. It is used by the blackjack controller for dealer draw delays, player-turn timeouts and LED/display hold times. Supports cancel, pause/resume and retrigger, and is wrap-safe across `time_ms` roll-over.

## Interface
- `WIDTH`, 32: width of the incoming `time_ms` count.
- `DUR_W`, 16: width of the duration request and `remaining`.

- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `time_ms`, in, `WIDTH`: monotonic tick count from the timebase; increments by 1 per tick, same clock domain.
- `start`, in, 1: load `dur` and begin timing. Accepted in any state.
- `dur`, in, `DUR_W`: duration in ticks, sampled only when `start`=1.
- `cancel`, in, 1: abort the current timing without expiry.
- `pause`, in, 1: freeze the elapsed count (RUN only).
- `resume`, in, 1: continue from the frozen count (HOLD only).
- `busy`, out, 1: high in RUN or HOLD.
- `paused`, out, 1: high in HOLD.
- `expired`, out, 1: one-cycle pulse on expiry.
- `remaining`, out, `DUR_W`: ticks left; 0 when idle.

## Operation
- States: IDLE, RUN, HOLD. Registers:
  - `stamp` (`WIDTH`): start reference.
  - `tgt` (`DUR_W`): requested duration.
  - `acc` (`WIDTH`): elapsed count frozen at pause.
- Elapsed time is `elapsed = time_ms - stamp`, computed modulo 2^`WIDTH`. This stays correct across `time_ms` roll-over as long as the true elapsed time is less than 2^`WIDTH`.
- Input priority per cycle: `cancel` > `start` > expiry > `pause`/`resume`.
- IDLE:
  - `start` with `dur`≠0 → RUN; `stamp`←`time_ms`, `tgt`←`dur`.
  - `start` with `dur`=0 → stay IDLE; `expired` pulses next cycle.
  - `cancel`, `pause`, `resume` are ignored.
- RUN:
  - `cancel` → IDLE, no pulse.
  - `start` → retrigger: reload `stamp` and `tgt`, stay RUN (the `dur`=0 rule still applies).
  - `elapsed` ≥ `tgt` (zero-extended) → IDLE with `expired` pulse.
  - `pause` → HOLD; `acc`←`elapsed`.
  - `resume` is ignored.
- HOLD:
  - `cancel` → IDLE, no pulse.
  - `start` → RUN with a fresh load.
  - `resume` → RUN; `stamp`←`time_ms - acc`.
  - `pause` is ignored; `time_ms` changes are ignored.
- `remaining`:
  - RUN: `tgt - elapsed`, clamped at 0.
  - HOLD: `tgt - acc`.
  - IDLE: 0.
- Reset mid-operation discards all state; no `expired` pulse is produced.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `paused`=0, `expired`=0, `remaining`=0, state IDLE; `stamp`, `tgt`, `acc` = 0.
- `start` sampled at edge N:
  - `busy`=1 from edge N.
  - `remaining`=`dur` after edge N.
- Expiry: the compare uses `time_ms` as sampled at edge M. If it is true, then after edge M:
  - `expired`=1, `busy`=0, `remaining`=0.
  - `expired` returns to 0 after edge M+1.
  - Net effect: `expired` rises one clock after `time_ms` first equals `stamp + tgt`.
- `dur`=0: `expired`=1 for the single cycle after the `start` edge; `busy` stays 0.
- `cancel` takes effect at the sampling edge: `busy`=0 and `remaining`=0 after it.
- Simultaneous events:
  - `start` in the same cycle as an expiry: the retrigger wins, no pulse.
  - `pause` in the same cycle as an expiry: the expiry wins.
- Back-to-back operation: `start` may be asserted in the same cycle `expired` is high; the new timing begins normally.

## Structure
- Shared package `timer_pkg`:
  - State enum `timer_state_t` {IDLE, RUN, HOLD}.
  - Default width constants `TIME_W`=32, `DUR_W`=16.
  - Tick-rate constant `TICKS_PER_SEC`, shared with the timebase.
- Single module; no sub-module is needed. The wrap-safe subtract/compare is a local expression.

## Test plan
- Basic timing and reset values:
  - Reset: all outputs 0.
  - `time_ms`=100, `start` with `dur`=5 → `busy`=1, `remaining` steps 5,4,…,1.
  - `time_ms`=105 → `expired` pulses one cycle later, `busy`=0.
- Wrap-around: `time_ms`=0xFFFF_FFFE, `dur`=4 → `expired` one cycle after `time_ms`=2; no early expiry at roll-over.
- Pause/resume:
  - `time_ms`=10, `dur`=10.
  - Pause at `time_ms`=13 → `remaining`=7, `paused`=1.
  - Hold until `time_ms`=50, then resume → `expired` one cycle after `time_ms`=57.
- Cancel and retrigger:
  - Cancel at `elapsed`=3 of 8 → no pulse ever.
  - Start with `dur`=8 at `time_ms`=0, restart with `dur`=8 at `time_ms`=6 → `expired` only after `time_ms`=14.
- Edge cases:
  - `dur`=0 → single `expired` pulse, `busy` never asserted.
  - `start` coinciding with an expiry → no pulse, new count loaded.
  - `rst` asserted mid-RUN → outputs 0 immediately, no pulse after release.
